// File: rtl/ram_burst_pkg.sv
// Shared constants and state encoding for the RAM burst initiator.
package ram_burst_pkg;

   localparam int unsigned AwDef = 10;
   localparam int unsigned DwDef = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2
   } state_e;

endpackage

// File: rtl/ram_burst_port_fifo.sv
// Two-entry read skid FIFO: absorbs RAM read latency while the sink stalls.
module rd_skid_fifo #(
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [1:0]    occ,
   output logic [DW-1:0] head
);

   logic [DW-1:0] mem_q [2];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + 2'(push) - 2'(pop);
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_burst_port.sv
// Burst initiator for one port of a synchronous-read block RAM, with valid/ready
// streaming on both the write-data and read-data sides.
module ram_burst_port
   import ram_burst_pkg::*;
#(
   parameter int unsigned AW = AwDef,
   parameter int unsigned DW = DwDef
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          done,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] cnt_q, cnt_d;          // words left to issue/write, minus one
   logic [AW-1:0] pop_cnt_q, pop_cnt_d;  // words left to pop, minus one
   logic          iss_done_q, iss_done_d;
   logic          inflight_q;
   logic          done_q, done_d;
   logic          issue;
   logic          pop;
   logic [1:0]    occ;

   assign rd_valid = (occ != 2'd0);
   assign pop      = rd_valid & rd_ready;
   assign ram_din  = wr_data;
   assign done     = done_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      pop_cnt_d  = pop_cnt_q;
      iss_done_d = iss_done_q;
      done_d     = 1'b0;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_q;
      issue      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d     = cmd_addr;
               cnt_d      = cmd_len;
               pop_cnt_d  = cmd_len;
               iss_done_d = 1'b0;
               state_d    = cmd_write ? StWrite : StRead;
            end
         end
         StWrite: begin
            wr_ready = 1'b1;
            ram_en   = wr_valid;
            ram_we   = wr_valid;
            if (wr_valid) begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         StRead: begin
            // Buffered + in-flight words, net of this cycle's pop, must leave room.
            issue = !iss_done_q && (({1'b0, occ} + 3'(inflight_q)) < (3'd2 + 3'(pop)));
            if (issue) begin
               ram_en = 1'b1;
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  iss_done_d = 1'b1;
               end
            end
            if (pop) begin
               pop_cnt_d = pop_cnt_q - 1'b1;
               if (pop_cnt_q == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cnt_q      <= '0;
         pop_cnt_q  <= '0;
         iss_done_q <= 1'b0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         iss_done_q <= iss_done_d;
         inflight_q <= issue;
         done_q     <= done_d;
      end
   end

   rd_skid_fifo #(
      .DW(DW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_data(ram_dout),
      .pop      (pop),
      .occ      (occ),
      .head     (rd_data)
   );

endmodule

// File: tb/tb_ram_burst_port.sv
// Scoreboard bench for ram_burst_port against a behavioural RAM and word-level model.
module tb_ram_burst_port;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW-1:0] cmd_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic          done;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;

   logic [DW-1:0] ram [1024];
   logic [DW-1:0] ref_mem [1024];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pops = 0;
   int done_seen = 0;
   int n_bursts = 0;
   int rd_mode = 0;  // 0: always ready, 1: random, 2: stalled

   logic [AW+DW-1:0] wq[$];
   logic [DW-1:0]    rq[$];
   logic [AW-1:0]    iaq[$];

   ram_burst_port #(
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .done     (done),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Behavioural synchronous-read RAM
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_din;
         else        ram_dout <= ram[ram_addr];
      end
   end

   always @(posedge clk) begin
      #1;
      case (rd_mode)
         0:       rd_ready = 1'b1;
         1:       rd_ready = ($urandom_range(0, 2) != 0);
         default: rd_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: pops expectations whenever the DUT presents a transfer
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (!rst) begin
         if (ram_en && ram_we) begin
            if (wq.size() == 0) fail("spurious_write");
            else begin
               e = wq.pop_front();
               chk("wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
               chk("wr_data", 32'(ram_din), 32'(e[DW-1:0]));
            end
         end
         if (ram_en && !ram_we) begin
            if (iaq.size() == 0) fail("spurious_read_issue");
            else chk("rd_issue_addr", 32'(ram_addr), 32'(iaq.pop_front()));
         end
         if (rd_valid && rd_ready) begin
            pops++;
            if (rq.size() == 0) fail("spurious_rd_word");
            else chk("rd_data", 32'(rd_data), 32'(rq.pop_front()));
         end
         if (done) done_seen++;
      end
   end

   task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] l,
                           output int acc);
      bit hs = 1'b0;
      int n = 0;
      acc = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs  = cmd_ready;
         acc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (!hs) fail("cmd_timeout");
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      int n = 0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         seen = done;
         n++;
      end
      chk("done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("queues_drained", 32'(wq.size() + rq.size() + iaq.size()), 32'd0);
      n_bursts++;
      @(posedge clk);
      #1;
   endtask

   task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                              input bit rand_valid, input bit use_base,
                              input logic [DW-1:0] base);
      int acc;
      send_cmd(1'b1, a, l, acc);
      for (int i = 0; i <= int'(l); i++) begin
         logic [AW-1:0] ad = a + AW'(i);
         logic [DW-1:0] d  = use_base ? base + DW'(i) : DW'($urandom);
         bit hs = 1'b0;
         int n = 0;
         wq.push_back({ad, d});
         ref_mem[ad] = d;
         wr_data = d;
         while (!hs && n < 100) begin
            wr_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            n++;
         end
         if (!hs) begin
            fail("wr_timeout");
            break;
         end
      end
      wr_valid = 1'b0;
      wait_done();
   endtask

   task automatic expect_read(input logic [AW-1:0] a, input logic [AW-1:0] l);
      for (int i = 0; i <= int'(l); i++) begin
         logic [AW-1:0] ad = a + AW'(i);
         iaq.push_back(ad);
         rq.push_back(ref_mem[ad]);
      end
   endtask

   task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l);
      int acc;
      expect_read(a, l);
      send_cmd(1'b0, a, l, acc);
      wait_done();
   endtask

   initial begin
      #900000;
      fail("global_timeout");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "bench stopped by timeout");
   end

   initial begin
      int acc;
      int en_cnt;
      int p0;
      int n;
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      @(posedge clk);
      #1;

      // Directed write 0xA000..0xA003 at 0x010
      write_burst(10'h010, 10'd3, 1'b0, 1'b1, 16'hA000);

      // Directed read with cycle-exact timing (L = 4)
      rd_mode = 0;
      expect_read(10'h010, 10'd3);
      send_cmd(1'b0, 10'h010, 10'd3, acc);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k <= 4) chk("rd_issue_slot", 32'(ram_en), 32'd1);
         chk("rd_valid_timing", 32'(rd_valid), 32'((k >= 3) && (k <= 6)));
         chk("done_timing", 32'(done), 32'(k == 7));
      end
      @(posedge clk);
      #1;
      chk("timed_read_drained", 32'(rq.size() + iaq.size()), 32'd0);
      n_bursts++;

      // Backpressure: stall the sink, only two reads may be issued
      rd_mode = 2;
      @(posedge clk);
      #2;
      expect_read(10'h010, 10'd3);
      send_cmd(1'b0, 10'h010, 10'd3, acc);
      en_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (ram_en) en_cnt++;
      end
      chk("bp_issue_count", 32'(en_cnt), 32'd2);
      chk("bp_rd_valid_held", 32'(rd_valid), 32'd1);
      chk("bp_no_pops", 32'(rq.size()), 32'd4);
      @(posedge clk);
      #1;
      rd_mode = 0;
      wait_done();

      // Address wrap
      write_burst(10'h3FE, 10'd3, 1'b1, 1'b0, 16'h0);
      read_burst(10'h3FE, 10'd3);

      // Asynchronous reset in the middle of an 8-word read
      expect_read(10'h010, 10'd7);
      send_cmd(1'b0, 10'h010, 10'd7, acc);
      p0 = pops;
      n  = 0;
      while (pops < p0 + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (pops < p0 + 2) fail("midread_pop_timeout");
      #2 rst = 1'b1;
      #1;
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("arst_wr_ready", 32'(wr_ready), 32'd0);
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      chk("arst_rd_data", 32'(rd_data), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ram_en", 32'(ram_en), 32'd0);
      chk("arst_ram_addr", 32'(ram_addr), 32'd0);
      rq.delete();
      iaq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      read_burst(10'h010, 10'd0);

      // Randomized bursts with random source and sink handshakes
      rd_mode = 1;
      for (int it = 0; it < 30; it++) begin
         logic [AW-1:0] a = AW'($urandom);
         logic [AW-1:0] l = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 40))
                                                         : AW'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) write_burst(a, l, 1'b1, 1'b0, 16'h0);
         else                           read_burst(a, l);
      end

      chk("done_count", 32'(done_seen), 32'(n_bursts));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
